csa_seq_mul: RTL and testbench

Iterative unsigned significand multiplier for the FPU, built around the shared 3:2 carry-save adder. It accepts one operand pair through a valid/ready handshake and adds one partial product per cycle into a redundant sum/carry accumulator. It then resolves the product with a single carry-propagate add and holds the result until the consumer takes it. It sits between FPU operand unpacking and normalisation/rounding, and replaces a full array multiplier where area matters more than latency.

---
 rtl/fpu_mul_pkg.sv | 18 +
 rtl/csa_seq_mul_if.sv | 27 ++
 rtl/three2add.sv | 18 +
 rtl/csa_seq_mul.sv | 139 +++++++++++++
 tb/tb_csa_seq_mul.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_mul_pkg.sv
// Shared types and helpers for the iterative significand multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_mul_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } mul_state_t;

   // Width of the partial-product index: ceil(log2(n)), never below one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/csa_seq_mul_if.sv
// Operand/product handshake bundle for csa_seq_mul.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the product side.
interface csa_seq_mul_if #(
   parameter int N = 53
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   logic             out_valid;
   logic             out_ready;
   logic [2*N-1:0]   p;
   logic             busy;

   // Producer/consumer side of the multiplier.
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p, busy
   );

   // The multiplier itself.
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p, busy
   );
endinterface

// File: rtl/three2add.sv
// 3:2 carry-save adder: reduces three n-bit addends to a sum vector and a carry vector.
// Latency: purely combinational.
// Backpressure: none.
module three2add #(
   parameter int n = 8
) (
   input  logic [n-1:0] x,
   input  logic [n-1:0] y,
   input  logic [n-1:0] z,
   output logic [n:0]   s,
   output logic [n:0]   t
);

   // Bitwise sum has no carry-out; majority carries shift up one place so t[0] is always 0.
   assign s = {1'b0, x ^ y ^ z};
   assign t = {(x & y) | (x & z) | (y & z), 1'b0};

endmodule

// File: rtl/csa_seq_mul.sv
// Iterative unsigned N x N multiplier: one partial product per cycle into a carry-save pair.
// Latency: N+1 cycles from acceptance to out_valid; one operation in flight, II = N+3.
// Backpressure: in_ready only in IDLE; the product is held in DONE until out_ready.
module csa_seq_mul
   import fpu_mul_pkg::*;
#(
   parameter int N = 53
) (
   input  logic         clk,
   input  logic         rst,
   csa_seq_mul_if.slave bus
);

   localparam int W  = 2 * N;
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   mul_state_t     state;
   mul_state_t     state_nxt;

   logic [N-1:0]   a_q;
   logic [N-1:0]   b_q;
   logic [W-1:0]   s_q;
   logic [W-1:0]   c_q;
   logic [W-1:0]   p_q;
   logic [W-1:0]   pp;
   logic [W:0]     csa_s;
   logic [W:0]     csa_t;
   logic [CW-1:0]  cnt;
   logic           last_step;
   logic           unused_csa_msb;

   assign last_step = (cnt == CNT_LAST);

   // Current partial product: multiplicand shifted to the weight of multiplier bit cnt.
   always_comb begin
      pp = '0;
      if (b_q[cnt]) begin
         pp = {{N{1'b0}}, a_q} << cnt;
      end
   end

   three2add #(
      .n (W)
   ) u_csa (
      .x (s_q),
      .y (c_q),
      .z (pp),
      .s (csa_s),
      .t (csa_t)
   );

   // The pair is exact modulo 2^W and the product fits in W bits, so bit W is discarded.
   assign unused_csa_msb = csa_s[W] ^ csa_t[W];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus handshake outputs decoded from state alone.
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            bus.busy = 1'b1;
            if (last_step) begin
               state_nxt = RESOLVE;
            end
         end
         RESOLVE: begin
            bus.busy  = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture, carry-save accumulation and the final carry-propagate add.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         s_q <= '0;
         c_q <= '0;
         cnt <= '0;
         p_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q <= bus.a;
                  b_q <= bus.b;
                  s_q <= '0;
                  c_q <= '0;
                  cnt <= '0;
               end
            end
            ACCUM: begin
               s_q <= csa_s[W-1:0];
               c_q <= csa_t[W-1:0];
               // Hold at N-1 on exit so the counter never wraps for power-of-two N.
               if (!last_step) begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESOLVE: begin
               p_q <= s_q + c_q;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.p = p_q;

endmodule

// File: tb/tb_csa_seq_mul.sv
// Self-checking bench for csa_seq_mul at N=8: vector table, corner sequences, random stalls.
// Latency: checks N+1 cycles acceptance-to-valid and N+3 back-to-back initiation.
// Backpressure: exercises out_ready stalls and ignored in_valid outside IDLE.
module tb_csa_seq_mul;

   localparam int N        = 8;
   localparam int W2       = 2 * N;
   localparam int LAT      = N + 1;
   localparam int II       = N + 3;
   localparam int NUM_RAND = 3000;

   typedef struct {
      logic [N-1:0]  a;
      logic [N-1:0]  b;
      logic [W2-1:0] p;
      int            hold;
   } vec_t;

   typedef struct {
      logic [W2-1:0] p;
      int            acc_edge;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   csa_seq_mul_if #(.N(N)) bif ();

   csa_seq_mul #(
      .N (N)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   int  errors   = 0;
   int  checks   = 0;
   int  cyc      = 0;
   int  acc_cnt  = 0;
   int  last_acc = 0;
   int  prev_acc = 0;
   bit  ov_prev  = 1'b0;
   sb_t sb_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: expected product pushed at acceptance, latency checked on the out_valid rise,
   // product checked and popped at handoff. A reset discards anything in flight.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         ov_prev = 1'b0;
      end else begin
         if (bif.in_valid && bif.in_ready) begin
            sb_q.push_back('{p: W2'(bif.a) * W2'(bif.b), acc_edge: cyc + 1});
            prev_acc = last_acc;
            last_acc = cyc + 1;
            acc_cnt++;
         end
         if (bif.out_valid && !ov_prev) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: out_valid rose with p=0x%0h, expected no output", bif.p);
            end else begin
               chk("sb_latency", 32'(cyc - sb_q[0].acc_edge), 32'(LAT));
            end
         end
         if (bif.out_valid && bif.out_ready && sb_q.size() != 0) begin
            chk("sb_product", 32'(bif.p), 32'(sb_q[0].p));
            void'(sb_q.pop_front());
         end
         ov_prev = bif.out_valid;
      end
   end

   // One operation with an optional stall of 'hold' cycles in DONE, pulsing in_valid meanwhile.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [W2-1:0] exp_p, input int hold);
      int n;
      n = 0;
      while (!bif.in_ready && n < 50) begin
         tick();
         n++;
      end
      chk("idle_before_op", 32'(bif.in_ready), 32'd1);
      bif.a         = a;
      bif.b         = b;
      bif.in_valid  = 1'b1;
      bif.out_ready = (hold == 0);
      tick();
      bif.in_valid = 1'b0;
      bif.a        = ~a;
      bif.b        = ~b;
      chk("busy_in_accum", 32'(bif.busy), 32'd1);
      chk("in_ready_in_accum", 32'(bif.in_ready), 32'd0);
      n = 0;
      while (!bif.out_valid && n < 40) begin
         tick();
         n++;
      end
      chk("latency_direct", 32'(n), 32'(LAT));
      chk("p_at_valid", 32'(bif.p), 32'(exp_p));
      for (int k = 0; k < hold; k++) begin
         bif.in_valid = (k % 2 == 0);
         bif.a        = 8'h5A;
         bif.b        = 8'hC3;
         tick();
         chk("hold_out_valid", 32'(bif.out_valid), 32'd1);
         chk("hold_p_stable", 32'(bif.p), 32'(exp_p));
         chk("hold_in_ready", 32'(bif.in_ready), 32'd0);
      end
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b1;
      tick();
      chk("in_ready_after_handoff", 32'(bif.in_ready), 32'd1);
      chk("out_valid_after_handoff", 32'(bif.out_valid), 32'd0);
   endtask

   initial begin
      vec_t tbl[4];
      int   n;
      int   ops;
      int   start;

      bif.in_valid  = 1'b0;
      bif.a         = '0;
      bif.b         = '0;
      bif.out_ready = 1'b1;
      rst           = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_in_ready", 32'(bif.in_ready), 32'd1);
      chk("reset_out_valid", 32'(bif.out_valid), 32'd0);
      chk("reset_busy", 32'(bif.busy), 32'd0);
      chk("reset_p", 32'(bif.p), 32'd0);

      tbl[0] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01, hold: 0};
      tbl[1] = '{a: 8'h00, b: 8'hB7, p: 16'h0000, hold: 0};
      tbl[2] = '{a: 8'h01, b: 8'h01, p: 16'h0001, hold: 0};
      tbl[3] = '{a: 8'h80, b: 8'h80, p: 16'h4000, hold: 5};
      for (int i = 0; i < 4; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].hold);
      end

      // Reset in the 4th ACCUM cycle discards the operation.
      bif.a        = 8'hAB;
      bif.b        = 8'hCD;
      bif.in_valid = 1'b1;
      tick();
      bif.in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("midop_busy", 32'(bif.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midop_rst_in_ready", 32'(bif.in_ready), 32'd1);
      chk("midop_rst_out_valid", 32'(bif.out_valid), 32'd0);
      chk("midop_rst_p", 32'(bif.p), 32'd0);
      chk("midop_rst_busy", 32'(bif.busy), 32'd0);
      run_op(8'h03, 8'h05, 16'h000F, 0);

      // Back-to-back: in_valid held high, second acceptance exactly II cycles later.
      start         = acc_cnt;
      bif.a         = 8'h12;
      bif.b         = 8'h34;
      bif.in_valid  = 1'b1;
      bif.out_ready = 1'b1;
      tick();
      bif.a = 8'h56;
      bif.b = 8'h78;
      n = 0;
      while (acc_cnt < start + 2 && n < 40) begin
         tick();
         n++;
      end
      bif.in_valid = 1'b0;
      chk("b2b_accepts", 32'(acc_cnt - start), 32'd2);
      chk("b2b_interval", 32'(last_acc - prev_acc), 32'(II));

      // Random operands with random consumer stalls.
      ops = 0;
      n   = 0;
      while (ops < NUM_RAND && n < NUM_RAND * 40) begin
         bif.out_ready = ($urandom_range(0, 3) != 0);
         if (bif.in_ready) begin
            bif.a        = 8'($urandom);
            bif.b        = 8'($urandom);
            bif.in_valid = 1'b1;
            ops++;
         end else begin
            bif.in_valid = 1'b0;
         end
         tick();
         n++;
      end
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b1;
      chk("rand_ops_issued", 32'(ops), 32'(NUM_RAND));

      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      tick();
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      chk("final_idle", 32'(bif.in_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: time limit reached at cycle %0d, expected completion earlier", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
